// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: funct codes, forwarding and destination
// selects, ALUOp classes and the multiply/divide sequencer types.
package ex_pkg;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_SLT   = 2'b11;

  typedef enum logic {IDLE, RUN} mdState_t;

  // Low two funct bits of 18h..1Bh select the operation directly.
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } mdOp_t;

  function automatic logic isMdFunct(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
  endfunction

  function automatic logic isHiLoFunct(input logic [5:0] f);
    return isMdFunct(f) || (f == FN_MFHI) || (f == FN_MTHI) ||
           (f == FN_MFLO) || (f == FN_MTLO);
  endfunction

endpackage

// File: rtl/stage_ex_md_if.sv
// ID/EX operand/control bundle into the execute stage and the EX/MEM latch outputs.
interface stage_ex_md_if #(
  parameter int XLEN = 32
);
  logic            mem_read, mem_write, reg_write, alu_src;
  logic [1:0]      reg_dst, mem_to_reg, alu_op;
  logic [5:0]      funct;
  logic [4:0]      sa;
  logic [1:0]      forward_a, forward_b;
  logic [XLEN-1:0] data_rs, data_rt, sign_ext, wb_data;
  logic [4:0]      reg_rt, reg_rd;

  logic [XLEN-1:0] out_alu, out_data_rt;
  logic [4:0]      out_mux_rt_rd, out_reg_rt;
  logic            out_mem_read, out_mem_write, out_reg_write;
  logic [1:0]      out_mem_to_reg;

  modport master (
    output mem_read, mem_write, reg_write, alu_src, reg_dst, mem_to_reg, alu_op,
           funct, sa, forward_a, forward_b, data_rs, data_rt, sign_ext, wb_data,
           reg_rt, reg_rd,
    input  out_alu, out_data_rt, out_mux_rt_rd, out_reg_rt, out_mem_read,
           out_mem_write, out_reg_write, out_mem_to_reg
  );

  modport slave (
    input  mem_read, mem_write, reg_write, alu_src, reg_dst, mem_to_reg, alu_op,
           funct, sa, forward_a, forward_b, data_rs, data_rt, sign_ext, wb_data,
           reg_rt, reg_rd,
    output out_alu, out_data_rt, out_mux_rt_rd, out_reg_rt, out_mem_read,
           out_mem_write, out_reg_write, out_mem_to_reg
  );
endinterface

// File: rtl/ex_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider retiring MD_STEP bits per cycle.
// Works on operand magnitudes; signs are reapplied combinationally on the done cycle.
module ex_muldiv_iter
  import ex_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MD_STEP = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  mdOp_t           op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            run,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int NSTEP = XLEN / MD_STEP;
  localparam int CW    = $clog2(NSTEP + 1);

  mdState_t        state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] accHi, accLo, opnd, nHi, nLo, magA, magB;
  logic [XLEN:0]   t, s;
  logic            qb, isDiv, negQ, negR, divZero, sgnOp, negA, negB, zeroDiv;
  logic [2*XLEN-1:0] prod;

  function automatic logic [XLEN-1:0] negIf(input logic n, input logic [XLEN-1:0] v);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] negIf2(input logic n, input logic [2*XLEN-1:0] v);
    return n ? -v : v;
  endfunction

  assign sgnOp   = ~op[0];
  assign negA    = sgnOp & a[XLEN-1];
  assign negB    = sgnOp & b[XLEN-1];
  assign magA    = negIf(negA, a);
  assign magB    = negIf(negB, b);
  assign zeroDiv = op[1] && (b == '0);
  assign run     = (state == RUN);
  assign done    = run && (cnt == CW'(1));

  // One iteration: MD_STEP shift-add or restoring-subtract steps.
  always_comb begin
    nHi = accHi;
    nLo = accLo;
    t   = '0;
    s   = '0;
    qb  = 1'b0;
    for (int i = 0; i < MD_STEP; i++) begin
      if (isDiv) begin
        t  = {nHi, nLo[XLEN-1]};
        qb = (t >= {1'b0, opnd});
        if (qb) t = t - {1'b0, opnd};
        nHi = t[XLEN-1:0];
        nLo = {nLo[XLEN-2:0], qb};
      end else begin
        s   = {1'b0, nHi} + (nLo[0] ? {1'b0, opnd} : '0);
        nHi = s[XLEN:1];
        nLo = {s[0], nLo[XLEN-1:1]};
      end
    end
  end

  always_comb begin
    prod = negIf2(negQ, {nHi, nLo});
    if (divZero) begin
      hi = accHi;
      lo = accLo;
    end else if (isDiv) begin
      hi = negIf(negR, nHi);
      lo = negIf(negQ, nLo);
    end else begin
      hi = prod[2*XLEN-1:XLEN];
      lo = prod[XLEN-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      isDiv   <= 1'b0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      divZero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state   <= RUN;
          isDiv   <= op[1];
          negQ    <= negA ^ negB;
          negR    <= negA;
          divZero <= zeroDiv;
          cnt     <= zeroDiv ? CW'(1) : CW'(NSTEP);
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; they are only observed through done.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      if (zeroDiv) begin
        accHi <= a;
        accLo <= '1;
        opnd  <= b;
      end else if (op[1]) begin
        accHi <= '0;
        accLo <= magA;
        opnd  <= magB;
      end else begin
        accHi <= '0;
        accLo <= magB;
        opnd  <= magA;
      end
    end else if (state == RUN) begin
      accHi <= nHi;
      accLo <= nLo;
    end
  end

endmodule

// File: rtl/stage_ex_md.sv
// Execute stage: operand forwarding, ALU, destination select, HI/LO with an
// iterative multiply/divide unit, and the EX/MEM pipeline latch.
module stage_ex_md
  import ex_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MD_STEP = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         in_flush,
  output logic         md_busy,
  stage_ex_md_if.slave bus
);

  logic [XLEN-1:0]        opA, opBFwd, opB, aluRes, hiR, loR, mdHi, mdLo;
  logic signed [XLEN-1:0] opAS, opBS;
  logic                   isRType, isMd, isHiLo, mdRun, mdDone, mdStart, mtHi, mtLo, accept;
  logic [4:0]             dstSel;

  logic [XLEN-1:0] aluP1, dataRtP1;
  logic [4:0]      dstP1, regRtP1;
  logic            memReadP1, memWriteP1, regWriteP1;
  logic [1:0]      memToRegP1;

  function automatic logic [XLEN-1:0] fwdSel(input logic [1:0] sel, input logic [XLEN-1:0] regV,
                                             input logic [XLEN-1:0] wbV, input logic [XLEN-1:0] memV);
    case (sel)
      FWD_REG: return regV;
      FWD_WB:  return wbV;
      FWD_MEM: return memV;
      default: return regV;
    endcase
  endfunction

  // p0: operand selection and decode
  assign opA     = fwdSel(bus.forward_a, bus.data_rs, bus.wb_data, aluP1);
  assign opBFwd  = fwdSel(bus.forward_b, bus.data_rt, bus.wb_data, aluP1);
  assign opB     = bus.alu_src ? bus.sign_ext : opBFwd;
  assign opAS    = opA;
  assign opBS    = opB;
  assign isRType = (bus.alu_op == ALUOP_RTYPE);
  assign isMd    = isRType && isMdFunct(bus.funct);
  assign isHiLo  = isRType && isHiLoFunct(bus.funct);
  assign accept  = enable && !in_flush;
  assign mdStart = accept && isMd && !mdRun;
  assign mtHi    = accept && isRType && (bus.funct == FN_MTHI);
  assign mtLo    = accept && isRType && (bus.funct == FN_MTLO);
  assign md_busy = mdRun && isHiLo;

  always_comb begin
    case (bus.reg_dst)
      RDST_RT: dstSel = bus.reg_rt;
      RDST_RD: dstSel = bus.reg_rd;
      RDST_RA: dstSel = 5'd31;
      default: dstSel = bus.reg_rt;
    endcase
  end

  always_comb begin
    aluRes = '0;
    case (bus.alu_op)
      ALUOP_ADD: aluRes = opA + opB;
      ALUOP_SUB: aluRes = opA - opB;
      ALUOP_SLT: aluRes = {{(XLEN-1){1'b0}}, opAS < opBS};
      default: begin
        case (bus.funct)
          FN_SLL:            aluRes = opB << bus.sa;
          FN_SRL:            aluRes = opB >> bus.sa;
          FN_SRA:            aluRes = opBS >>> bus.sa;
          FN_SLLV:           aluRes = opB << opA[4:0];
          FN_SRLV:           aluRes = opB >> opA[4:0];
          FN_SRAV:           aluRes = opBS >>> opA[4:0];
          FN_MFHI:           aluRes = hiR;
          FN_MFLO:           aluRes = loR;
          FN_ADD, FN_ADDU:   aluRes = opA + opB;
          FN_SUB, FN_SUBU:   aluRes = opA - opB;
          FN_AND:            aluRes = opA & opB;
          FN_OR:             aluRes = opA | opB;
          FN_XOR:            aluRes = opA ^ opB;
          FN_NOR:            aluRes = ~(opA | opB);
          FN_SLT:            aluRes = {{(XLEN-1){1'b0}}, opAS < opBS};
          FN_SLTU:           aluRes = {{(XLEN-1){1'b0}}, opA < opB};
          default:           aluRes = '0;
        endcase
      end
    endcase
  end

  ex_muldiv_iter #(
    .XLEN    (XLEN),
    .MD_STEP (MD_STEP)
  ) uMd (
    .clk   (clk),
    .reset (reset),
    .start (mdStart),
    .op    (mdOp_t'(bus.funct[1:0])),
    .a     (opA),
    .b     (opBFwd),
    .run   (mdRun),
    .done  (mdDone),
    .hi    (mdHi),
    .lo    (mdLo)
  );

  // MT writes cannot coincide with completion: the hazard unit stalls them during RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      hiR <= '0;
      loR <= '0;
    end else if (mdDone) begin
      hiR <= mdHi;
      loR <= mdLo;
    end else begin
      if (mtHi) hiR <= opA;
      if (mtLo) loR <= opA;
    end
  end

  // p1: EX/MEM latch; a flush loads data but kills the side-effecting controls
  always_ff @(posedge clk) begin
    if (reset) begin
      aluP1      <= '0;
      dataRtP1   <= '0;
      dstP1      <= '0;
      regRtP1    <= '0;
      memToRegP1 <= '0;
      memReadP1  <= 1'b0;
      memWriteP1 <= 1'b0;
      regWriteP1 <= 1'b0;
    end else if (in_flush || enable) begin
      aluP1      <= aluRes;
      dataRtP1   <= opBFwd;
      dstP1      <= dstSel;
      regRtP1    <= bus.reg_rt;
      memToRegP1 <= bus.mem_to_reg;
      memReadP1  <= bus.mem_read  && !in_flush;
      memWriteP1 <= bus.mem_write && !in_flush;
      regWriteP1 <= bus.reg_write && !in_flush;
    end
  end

  assign bus.out_alu        = aluP1;
  assign bus.out_data_rt    = dataRtP1;
  assign bus.out_mux_rt_rd  = dstP1;
  assign bus.out_reg_rt     = regRtP1;
  assign bus.out_mem_to_reg = memToRegP1;
  assign bus.out_mem_read   = memReadP1;
  assign bus.out_mem_write  = memWriteP1;
  assign bus.out_reg_write  = regWriteP1;

endmodule

// File: tb/tb_stage_ex_md.sv
// Directed bench for stage_ex_md: ALU/forwarding vector table plus hand-written
// multiply/divide, HI/LO, flush/hold and reset sequences.
module tb_stage_ex_md;
  import ex_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset, enable, in_flush, md_busy;
  int   checks = 0;
  int   errors = 0;

  stage_ex_md_if #(.XLEN(XLEN)) bus ();

  stage_ex_md #(.XLEN(XLEN), .MD_STEP(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .in_flush (in_flush),
    .md_busy  (md_busy),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  fa, fb, aluOp;
    logic [5:0]  funct;
    logic        aluSrc;
    logic [4:0]  sa;
    logic [1:0]  regDst;
    logic [31:0] rs, rt, se, wb, expAlu, expRt;
    logic [4:0]  expDst;
  } vec_t;

  vec_t vecs[18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.reg_write = 1'b0; bus.alu_src = 1'b0;
    bus.reg_dst = 2'b00; bus.mem_to_reg = 2'b00; bus.alu_op = ALUOP_ADD; bus.funct = 6'h00;
    bus.sa = 5'd0; bus.forward_a = 2'b00; bus.forward_b = 2'b00;
    bus.data_rs = '0; bus.data_rt = '0; bus.sign_ext = '0; bus.wb_data = '0;
    bus.reg_rt = 5'd7; bus.reg_rd = 5'd9;
  endtask

  task automatic setOp(input logic [1:0] aop, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt);
    bus.alu_op = aop; bus.funct = fn; bus.data_rs = rs; bus.data_rt = rt;
  endtask

  task automatic runMd(input string nm, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input int expBusy, input logic [31:0] expLo,
                       input logic [31:0] expHi, input bit overlap);
    int cnt;
    idle();
    enable = 1'b1;
    setOp(ALUOP_RTYPE, fn, a, b);
    tick();
    if (overlap) begin
      setOp(ALUOP_RTYPE, FN_ADD, 32'd1, 32'd1);
      #1;
      chk({nm, " overlap busy"}, 32'(md_busy), 32'd0);
      tick();
      chk({nm, " overlap alu"}, bus.out_alu, 32'd2);
    end
    setOp(ALUOP_RTYPE, FN_MFLO, 32'd0, 32'd0);
    enable = 1'b0;
    #1;
    cnt = 0;
    while (md_busy === 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
    chk({nm, " busy cycles"}, 32'(cnt), 32'(expBusy));
    enable = 1'b1;
    tick();
    chk({nm, " lo"}, bus.out_alu, expLo);
    setOp(ALUOP_RTYPE, FN_MFHI, 32'd0, 32'd0);
    tick();
    chk({nm, " hi"}, bus.out_alu, expHi);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{2'b01, 2'b00, ALUOP_RTYPE, FN_ADD,  1'b0, 5'd0, 2'b00, 32'd5,        32'd3,        32'd0,        32'd7,   32'd10,       32'd3,        5'd7};
    vecs[1]  = '{2'b00, 2'b10, ALUOP_RTYPE, FN_SUB,  1'b0, 5'd0, 2'b01, 32'd25,       32'd0,        32'd0,        32'd0,   32'd15,       32'd10,       5'd9};
    vecs[2]  = '{2'b00, 2'b00, ALUOP_RTYPE, FN_AND,  1'b0, 5'd0, 2'b10, 32'h0000F0F0, 32'h0000FF00, 32'd0,        32'd0,   32'h0000F000, 32'h0000FF00, 5'd31};
    vecs[3]  = '{2'b00, 2'b00, ALUOP_RTYPE, FN_OR,   1'b0, 5'd0, 2'b11, 32'h0000F0F0, 32'h0000FF00, 32'd0,        32'd0,   32'h0000FFF0, 32'h0000FF00, 5'd7};
    vecs[4]  = '{2'b00, 2'b00, ALUOP_RTYPE, FN_XOR,  1'b0, 5'd0, 2'b00, 32'h0000F0F0, 32'h0000FF00, 32'd0,        32'd0,   32'h00000FF0, 32'h0000FF00, 5'd7};
    vecs[5]  = '{2'b00, 2'b00, ALUOP_RTYPE, FN_NOR,  1'b0, 5'd0, 2'b01, 32'd0,        32'd0,        32'd0,        32'd0,   32'hFFFFFFFF, 32'd0,        5'd9};
    vecs[6]  = '{2'b00, 2'b00, ALUOP_RTYPE, FN_SLT,  1'b0, 5'd0, 2'b00, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,   32'd1,        32'd1,        5'd7};
    vecs[7]  = '{2'b00, 2'b00, ALUOP_RTYPE, FN_SLTU, 1'b0, 5'd0, 2'b00, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,   32'd0,        32'd1,        5'd7};
    vecs[8]  = '{2'b00, 2'b00, ALUOP_RTYPE, FN_SLL,  1'b0, 5'd4, 2'b00, 32'd0,        32'd1,        32'd0,        32'd0,   32'd16,       32'd1,        5'd7};
    vecs[9]  = '{2'b00, 2'b00, ALUOP_RTYPE, FN_SRA,  1'b0, 5'd4, 2'b00, 32'd0,        32'h80000000, 32'd0,        32'd0,   32'hF8000000, 32'h80000000, 5'd7};
    vecs[10] = '{2'b00, 2'b00, ALUOP_RTYPE, FN_SRL,  1'b0, 5'd4, 2'b00, 32'd0,        32'h80000000, 32'd0,        32'd0,   32'h08000000, 32'h80000000, 5'd7};
    vecs[11] = '{2'b00, 2'b00, ALUOP_RTYPE, FN_SLLV, 1'b0, 5'd0, 2'b00, 32'd3,        32'd5,        32'd0,        32'd0,   32'h00000028, 32'd5,        5'd7};
    vecs[12] = '{2'b00, 2'b00, ALUOP_RTYPE, FN_SRAV, 1'b0, 5'd0, 2'b00, 32'd33,       32'hFFFFFFF0, 32'd0,        32'd0,   32'hFFFFFFF8, 32'hFFFFFFF0, 5'd7};
    vecs[13] = '{2'b00, 2'b00, ALUOP_ADD,   6'h00,   1'b1, 5'd0, 2'b00, 32'd100,      32'd0,        32'hFFFFFFFC, 32'd0,   32'd96,       32'd0,        5'd7};
    vecs[14] = '{2'b00, 2'b00, ALUOP_SUB,   6'h00,   1'b0, 5'd0, 2'b00, 32'd5,        32'd9,        32'd0,        32'd0,   32'hFFFFFFFC, 32'd9,        5'd7};
    vecs[15] = '{2'b00, 2'b00, ALUOP_SLT,   6'h00,   1'b1, 5'd0, 2'b00, 32'hFFFFFFFB, 32'd0,        32'd2,        32'd0,   32'd1,        32'd0,        5'd7};
    vecs[16] = '{2'b11, 2'b00, ALUOP_RTYPE, FN_ADD,  1'b0, 5'd0, 2'b00, 32'd2,        32'd3,        32'd0,        32'd100, 32'd5,        32'd3,        5'd7};
    vecs[17] = '{2'b00, 2'b01, ALUOP_ADD,   6'h00,   1'b1, 5'd0, 2'b00, 32'd1,        32'd9,        32'd2,        32'h55,  32'd3,        32'h55,       5'd7};

    // Reset dominates live inputs
    idle();
    reset = 1'b1; enable = 1'b1; in_flush = 1'b0;
    setOp(ALUOP_RTYPE, FN_ADD, 32'd5, 32'd6);
    bus.reg_write = 1'b1; bus.reg_dst = RDST_RD;
    tick(); tick();
    chk("reset out_alu", bus.out_alu, 32'd0);
    chk("reset out_data_rt", bus.out_data_rt, 32'd0);
    chk("reset out_reg_write", 32'(bus.out_reg_write), 32'd0);
    chk("reset out_mux_rt_rd", 32'(bus.out_mux_rt_rd), 32'd0);
    chk("reset md_busy", 32'(md_busy), 32'd0);
    reset = 1'b0;

    // Flush kills controls but loads data; enable=0 holds
    idle();
    setOp(ALUOP_RTYPE, FN_ADD, 32'd1, 32'd2);
    bus.reg_write = 1'b1; bus.mem_write = 1'b1; bus.mem_read = 1'b1; bus.mem_to_reg = 2'b01;
    in_flush = 1'b1;
    tick();
    chk("flush reg_write", 32'(bus.out_reg_write), 32'd0);
    chk("flush mem_write", 32'(bus.out_mem_write), 32'd0);
    chk("flush mem_read", 32'(bus.out_mem_read), 32'd0);
    chk("flush alu", bus.out_alu, 32'd3);
    chk("flush mem_to_reg", 32'(bus.out_mem_to_reg), 32'd1);
    in_flush = 1'b0;
    tick();
    chk("noflush reg_write", 32'(bus.out_reg_write), 32'd1);
    chk("noflush mem_write", 32'(bus.out_mem_write), 32'd1);
    enable = 1'b0;
    setOp(ALUOP_RTYPE, FN_SUB, 32'd50, 32'd8);
    bus.reg_write = 1'b0;
    tick(); tick();
    chk("hold alu", bus.out_alu, 32'd3);
    chk("hold reg_write", 32'(bus.out_reg_write), 32'd1);
    enable = 1'b1;

    for (int i = 0; i < 18; i++) begin
      idle();
      bus.forward_a = vecs[i].fa;     bus.forward_b = vecs[i].fb;
      bus.alu_op    = vecs[i].aluOp;  bus.funct     = vecs[i].funct;
      bus.alu_src   = vecs[i].aluSrc; bus.sa        = vecs[i].sa;
      bus.reg_dst   = vecs[i].regDst;
      bus.data_rs   = vecs[i].rs;     bus.data_rt   = vecs[i].rt;
      bus.sign_ext  = vecs[i].se;     bus.wb_data   = vecs[i].wb;
      tick();
      chk($sformatf("vec%0d alu", i), bus.out_alu, vecs[i].expAlu);
      chk($sformatf("vec%0d data_rt", i), bus.out_data_rt, vecs[i].expRt);
      chk($sformatf("vec%0d dst", i), 32'(bus.out_mux_rt_rd), 32'(vecs[i].expDst));
    end

    // MTLO/MTHI then read back
    idle();
    setOp(ALUOP_RTYPE, FN_MTLO, 32'h1234, 32'd0); tick();
    setOp(ALUOP_RTYPE, FN_MFLO, 32'd0, 32'd0);    tick();
    chk("mtlo/mflo", bus.out_alu, 32'h1234);
    setOp(ALUOP_RTYPE, FN_MTHI, 32'hABCD, 32'd0); tick();
    setOp(ALUOP_RTYPE, FN_MFHI, 32'd0, 32'd0);    tick();
    chk("mthi/mfhi", bus.out_alu, 32'hABCD);

    runMd("mult",  FN_MULT,  32'hFFFFFFFD, 32'd4, 32, 32'hFFFFFFF4, 32'hFFFFFFFF, 1'b0);
    runMd("div",   FN_DIV,   32'hFFFFFFF9, 32'd2, 31, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b1);
    runMd("divu0", FN_DIVU,  32'd7,        32'd0, 1,  32'hFFFFFFFF, 32'd7,        1'b0);
    runMd("multu", FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'h00000001, 32'hFFFFFFFE, 1'b0);

    // Reset in the middle of a multiply
    idle();
    setOp(ALUOP_RTYPE, FN_MULT, 32'd5, 32'd6);
    bus.reg_dst = RDST_RD;
    tick();
    chk("mdrst launch dst", 32'(bus.out_mux_rt_rd), 32'd9);
    chk("mdrst launch data_rt", bus.out_data_rt, 32'd6);
    setOp(ALUOP_RTYPE, FN_MFHI, 32'd0, 32'd0);
    enable = 1'b0;
    repeat (5) tick();
    chk("mdrst busy before", 32'(md_busy), 32'd1);
    reset = 1'b1;
    tick();
    chk("mdrst busy", 32'(md_busy), 32'd0);
    chk("mdrst dst", 32'(bus.out_mux_rt_rd), 32'd0);
    chk("mdrst data_rt", bus.out_data_rt, 32'd0);
    reset = 1'b0;
    enable = 1'b1;
    tick();
    chk("mdrst hi", bus.out_alu, 32'd0);
    chk("mdrst busy after", 32'(md_busy), 32'd0);
    setOp(ALUOP_RTYPE, FN_MFLO, 32'd0, 32'd0);
    tick();
    chk("mdrst lo", bus.out_alu, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
